regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 133 +++++++++++++
 tb/tb_regfile_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write / 2-read register file with a per-register load
// scoreboard and a sequential clear engine.
//   clk, rst            clock, asynchronous active-high reset
//   we0/wa0/wd0         write port 0
//   we1/wa1/wd1         write port 1 (wins over port 0 on address collision)
//   ra0/rd0/rd0_busy    read port 0: data and pending bit
//   ra1/rd1/rd1_busy    read port 1: data and pending bit
//   bset/bset_a         mark a register pending (load issued)
//   clr_req/clr_busy    start / status of the register-by-register clear
//   v0                  stored value of register 2, never bypassed
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              rd0_busy,
  output logic              rd1_busy,
  input  logic              bset,
  input  logic [ADDR_W-1:0] bset_a,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] v0
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;

  logic byp;
  logic wr0_ok, wr1_ok, bset_ok;
  logic hit0_r0, hit1_r0, hit0_r1, hit1_r1;

  assign wr0_ok  = we0 && (wa0 != '0);
  assign wr1_ok  = we1 && (wa1 != '0);
  assign bset_ok = bset && (bset_a != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clr_req) state_nx = CLEAR;
      CLEAR:   if (idx == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);

  // Port 1 is applied after port 0 so it wins a same-address collision;
  // bset is applied last so a new load outranks the write's clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
      idx     <= '0;
    end else if (state == CLEAR) begin
      regs[idx]    <= '0;
      pending[idx] <= 1'b0;
      idx          <= idx + 1'b1;
    end else begin
      if (wr0_ok) begin
        regs[wa0]    <= wd0;
        pending[wa0] <= 1'b0;
      end
      if (wr1_ok) begin
        regs[wa1]    <= wd1;
        pending[wa1] <= 1'b0;
      end
      if (bset_ok) pending[bset_a] <= 1'b1;
      if (clr_req) idx <= ADDR_W'(1);
    end
  end

  // Forwarding only while idle and out of reset; the clear engine and reset
  // must expose stored contents only.
  assign byp = (BYPASS != 0) && (state == IDLE) && !rst;

  assign hit0_r0 = byp && wr0_ok && (wa0 == ra0);
  assign hit1_r0 = byp && wr1_ok && (wa1 == ra0);
  assign hit0_r1 = byp && wr0_ok && (wa0 == ra1);
  assign hit1_r1 = byp && wr1_ok && (wa1 == ra1);

  always_comb begin
    rd0      = regs[ra0];
    rd0_busy = pending[ra0];
    if (ra0 == '0) begin
      rd0      = '0;
      rd0_busy = 1'b0;
    end else begin
      if (hit1_r0)      rd0 = wd1;
      else if (hit0_r0) rd0 = wd0;
      if ((hit0_r0 || hit1_r0) && !(bset_ok && bset_a == ra0)) rd0_busy = 1'b0;
    end
  end

  always_comb begin
    rd1      = regs[ra1];
    rd1_busy = pending[ra1];
    if (ra1 == '0) begin
      rd1      = '0;
      rd1_busy = 1'b0;
    end else begin
      if (hit1_r1)      rd1 = wd1;
      else if (hit0_r1) rd1 = wd0;
      if ((hit0_r1 || hit1_r1) && !(bset_ok && bset_a == ra1)) rd1_busy = 1'b0;
    end
  end

  assign v0 = regs[2];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a forwarding instance and a
// non-forwarding instance share all stimulus.
module tb_regfile_mp;

  logic        clk, rst;
  logic        we0, we1, bset, clr_req;
  logic [4:0]  wa0, wa1, ra0, ra1, bset_a;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0, rd1, v0;
  logic        rd0_busy, rd1_busy, clr_busy;
  logic [31:0] nb_rd0, nb_rd1, nb_v0;
  logic        nb_rd0_busy, nb_rd1_busy, nb_clr_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .bset(bset), .bset_a(bset_a),
    .clr_req(clr_req), .clr_busy(clr_busy), .v0(v0)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(nb_rd0), .rd1(nb_rd1),
    .rd0_busy(nb_rd0_busy), .rd1_busy(nb_rd1_busy),
    .bset(bset), .bset_a(bset_a),
    .clr_req(clr_req), .clr_busy(nb_clr_busy), .v0(nb_v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic        bset; logic [4:0] bset_a;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_b0;  logic        e_b1;
    logic [31:0] e_nb1;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rd0, rd1, nb1;
    logic        b0, b1;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
    ra0 = 0; ra1 = 0; bset = 0; bset_a = 0; clr_req = 0;
  endtask

  initial begin
    exp_t e;
    idle_inputs();
    rst = 0;

    //            we0 wa0 wd0           we1 wa1 wd1    ra0 ra1 bs bsa rd0           rd1           b0 b1 nb1
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0};
    vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  5,  0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0};
    vecs[2]  = '{1, 0, 32'h1234,     0, 0, 32'h0,  0,  5, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
    vecs[3]  = '{1, 7, 32'h11,       1, 7, 32'h22, 5,  7, 0, 0, 32'hDEADBEEF, 32'h22,       0, 0, 32'h0};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,  7,  7, 0, 0, 32'h22,       32'h22,       0, 0, 32'h22};
    vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,  9,  0, 1, 9, 32'h0,        32'h0,        0, 0, 32'h0};
    vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,  9,  0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0};
    vecs[7]  = '{0, 0, 32'h0,        1, 9, 32'hAB, 9,  9, 0, 0, 32'hAB,       32'hAB,       0, 0, 32'h0};
    vecs[8]  = '{1, 9, 32'hCD,       0, 0, 32'h0,  9,  9, 1, 9, 32'hCD,       32'hCD,       0, 0, 32'hAB};
    vecs[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,  9,  9, 0, 0, 32'hCD,       32'hCD,       1, 1, 32'hCD};
    vecs[10] = '{1, 0, 32'h77,       0, 0, 32'h0,  0,  9, 1, 0, 32'h0,        32'hCD,       0, 1, 32'hCD};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,  0,  9, 0, 0, 32'h0,        32'hCD,       0, 1, 32'hCD};

    // Reset state, asserted asynchronously away from any edge.
    #1 rst = 1;
    #1;
    check("reset_rd0", rd0, 0);
    check("reset_rd1", rd1, 0);
    check("reset_v0", v0, 0);
    check("reset_busy", {30'd0, rd0_busy, rd1_busy}, 0);
    check("reset_clr_busy", {31'd0, clr_busy}, 0);
    #10 rst = 0;

    // Table vectors through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      bset = vecs[i].bset; bset_a = vecs[i].bset_a;
      sb.push_back('{i, vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_nb1, vecs[i].e_b0, vecs[i].e_b1});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_rd0", e.id), rd0, e.rd0);
      check($sformatf("vec%0d_rd1", e.id), rd1, e.rd1);
      check($sformatf("vec%0d_busy0", e.id), {31'd0, rd0_busy}, {31'd0, e.b0});
      check($sformatf("vec%0d_busy1", e.id), {31'd0, rd1_busy}, {31'd0, e.b1});
      check($sformatf("vec%0d_nb_rd1", e.id), nb_rd1, e.nb1);
    end
    check("sb_drained", sb.size(), 0);

    // Fill 1..31 with their index; forwarding on rd0, stored value on nb rd1.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      we0 = 1; wa0 = 5'(i); wd0 = 32'(i);
      ra0 = 5'(i); ra1 = 5'(i - 1);
      @(negedge clk);
      check($sformatf("fill%0d_byp", i), rd0, 32'(i));
      check($sformatf("fill%0d_nb", i), nb_rd1, 32'(i - 1));
    end

    @(posedge clk); #1;
    idle_inputs();
    bset = 1; bset_a = 12; ra0 = 31;
    @(negedge clk);
    check("fill31_stored", rd0, 31);

    // clr_req together with a write: the write commits, clear starts next.
    @(posedge clk); #1;
    idle_inputs();
    clr_req = 1; we0 = 1; wa0 = 4; wd0 = 32'h44; ra0 = 4; ra1 = 12;
    @(negedge clk);
    check("clrreq_byp", rd0, 32'h44);
    check("clrreq_busy12", {31'd0, rd1_busy}, 1);
    check("clrreq_not_busy_yet", {31'd0, clr_busy}, 0);

    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (cnt == 0) ra0 = 4;
      if (cnt == 10) begin
        we0 = 1; wa0 = 3; wd0 = 32'h333; we1 = 1; wa1 = 20; wd1 = 32'h999;
        ra0 = 20; ra1 = 3; bset = 1; bset_a = 20;
      end
      @(negedge clk);
      if (!clr_busy) break;
      cnt++;
      if (cnt == 1) check("clear_write_committed", rd0, 32'h44);
      if (cnt == 11) begin
        check("clear_rd0_uncleared", rd0, 20);
        check("clear_rd1_no_bypass", rd1, 0);
        check("clear_busy_ignores_bset", {31'd0, rd0_busy}, 0);
      end
    end
    check("clear_cycles", cnt, 31);

    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      ra0 = 5'(i); ra1 = 5'(i);
      @(negedge clk);
      check($sformatf("cleared%0d", i), rd0, 0);
      check($sformatf("cleared%0d_busy", i), {31'd0, rd0_busy}, 0);
      check($sformatf("cleared%0d_nb", i), nb_rd1, 0);
    end

    // Reset pulse between edges in the middle of a clear.
    @(posedge clk); #1;
    idle_inputs();
    we0 = 1; wa0 = 2; wd0 = 32'h55;
    @(posedge clk); #1;
    idle_inputs();
    clr_req = 1;
    @(posedge clk); #1;
    idle_inputs();
    ra0 = 2; ra1 = 2;
    @(negedge clk);
    check("midclear_busy", {31'd0, clr_busy}, 1);
    check("midclear_v0", v0, 32'h55);
    #2 rst = 1;
    #1;
    check("rst_mid_rd0", rd0, 0);
    check("rst_mid_rd1", rd1, 0);
    check("rst_mid_v0", v0, 0);
    check("rst_mid_busy", {30'd0, rd0_busy, rd1_busy}, 0);
    check("rst_mid_clr_busy", {31'd0, clr_busy}, 0);
    rst = 0;
    we0 = 1; wa0 = 2; wd0 = 32'hCAFE;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("post_rst_v0", v0, 32'hCAFE);
    check("post_rst_nb_v0", nb_v0, 32'hCAFE);
    check("post_rst_idle", {31'd0, clr_busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
